fetch_bundle_queue: RTL and testbench
=====================================

# fetch_bundle_queue

Parametrised multi-entry FIFO for fetch bundles between the frontend fetch stage and the fetch buffer. It replaces the single-entry pipe queue with configurable depth, payload width, pipe/flow modes, a synchronous flush for redirects, and occupancy reporting. Payload is an opaque `WIDTH`-bit vector packed by the producer; the queue never interprets it.

## Interface
- `DEPTH`, 2 — number of storage entries, any integer ≥ 1 (need not be a power of two).
- `WIDTH`, 255 — payload width in bits (255 = packed fetch bundle).
- `PIPE`, 1 — 1: enqueue accepted when full if a dequeue fires the same cycle.
- `FLOW`, 0 — 1: when empty, enqueue data passes combinationally to dequeue.
- `AF_LEVEL`, DEPTH-1 — `io_almost_full` asserts when count ≥ AF_LEVEL; range 1..DEPTH.

- `clock` in 1 — sole clock, rising edge.
- `reset` in 1 — asynchronous, active-high; clears all control state.
- `io_enq_ready` out 1 — queue accepts payload this cycle.
- `io_enq_valid` in 1 — producer offers payload.
- `io_enq_bits` in WIDTH — payload.
- `io_deq_ready` in 1 — consumer accepts head.
- `io_deq_valid` out 1 — head payload available.
- `io_deq_bits` out WIDTH — head payload.
- `io_flush` in 1 — discard all contents (frontend redirect).
- `io_count` out $clog2(DEPTH+1) — current occupancy, registered.
- `io_almost_full` out 1 — count ≥ AF_LEVEL, registered-derived.

## Operation
- State: `enq_ptr`, `deq_ptr` (each $clog2(DEPTH) bits, min 1), `count` (0..DEPTH). Storage not reset.
- empty = (count == 0); full = (count == DEPTH).
- io_enq_ready = ~io_flush & (~full | (PIPE & io_deq_ready)).
- io_deq_valid = ~io_flush & (~empty | (FLOW & io_enq_valid)).
- io_deq_bits = empty & FLOW ? io_enq_bits : storage[deq_ptr].
- do_enq = io_enq_valid & io_enq_ready; do_deq = io_deq_valid & io_deq_ready.
- Flow bypass: empty & FLOW & do_enq & do_deq → nothing written, pointers and count unchanged.
- Otherwise do_enq writes storage[enq_ptr], enq_ptr advances; do_deq advances deq_ptr.
- Pointer increment wraps DEPTH-1 → 0 explicitly (no modulo-2^n reliance).
- count_next = count + do_enq − do_deq (bypass case: net 0); never exceeds DEPTH nor drops below 0.
- Flush: has priority over everything; next edge sets enq_ptr = deq_ptr = 0, count = 0. Handshakes are forced off during flush, so no transfer occurs in a flush cycle.
- Reset (any time, including mid-transfer): pointers and count clear immediately; in-flight payload is lost.

## Timing
- Latency enq → deq: 1 cycle (FLOW=0); 0 cycles when empty and FLOW=1.
- Full-throughput: one enq and one deq per cycle sustained for DEPTH ≥ 1 with PIPE=1; with PIPE=0 and DEPTH=1, 50 % throughput.
- Reset values: io_enq_ready = 1, io_deq_valid = 0 (or io_enq_valid if FLOW), io_count = 0, io_almost_full = 0.
- io_count and io_almost_full reflect state after the previous edge; no combinational path from inputs.
- io_enq_ready depends combinationally on io_deq_ready only when PIPE=1; io_deq_valid/bits depend on io_enq_* only when FLOW=1.
- Simultaneous enq+deq when full (PIPE=1): head leaves, new entry written to freed slot, count stays DEPTH.

## Structure
- Shared package `frontend_queue_pkg`: `FETCH_BUNDLE_W = 255`, field offsets of the packed fetch bundle (pc[39:0], data[167:40], mask[175:168], xcpt[178:176], ghist[250:179], fsrc[252:251], tsrc[254:253]), and a `cnt_w(depth)` function.
- One sub-module: `fetch_queue_ram` — DEPTH×WIDTH register array, one write port, one asynchronous read port, no reset.
- Top holds pointers, count, handshake logic.

## Test plan
- Fill/drain, DEPTH=4, PIPE=0: enqueue 0x1..0x4 with deq_ready=0 → count 4, enq_ready=0, almost_full=1 from count 3; drain → 0x1..0x4 in order, count back to 0.
- Wrap, DEPTH=3: 10 enq/deq pairs interleaved with random stalls → output sequence identical to input, pointers wrap after index 2.
- Pipe full, DEPTH=2, PIPE=1: full with A,B; enq C with deq_ready=1 → B head next cycle, C stored, count stays 2.
- Flow, FLOW=1, empty: enq_valid=1 bits=0xAB, deq_ready=1 → deq_valid=1, deq_bits=0xAB same cycle, count stays 0.
- Flush: count=3, assert io_flush with enq_valid=1 → enq_ready=0, deq_valid=0 that cycle; next cycle count=0, deq_valid=0.
- Async reset mid-burst: assert reset between edges with count=2 → io_count=0, io_deq_valid=0 before the next clock edge.

Source files
------------

// File: rtl/fetch_bundle_queue_pkg.sv
// frontend_queue_pkg: shared widths, fetch bundle field offsets and sizing helpers for frontend queues
package frontend_queue_pkg;
    localparam int FETCH_BUNDLE_W = 255;
    localparam int PC_LSB = 0;
    localparam int PC_MSB = 39;
    localparam int DATA_LSB = 40;
    localparam int DATA_MSB = 167;
    localparam int MASK_LSB = 168;
    localparam int MASK_MSB = 175;
    localparam int XCPT_LSB = 176;
    localparam int XCPT_MSB = 178;
    localparam int GHIST_LSB = 179;
    localparam int GHIST_MSB = 250;
    localparam int FSRC_LSB = 251;
    localparam int FSRC_MSB = 252;
    localparam int TSRC_LSB = 253;
    localparam int TSRC_MSB = 254;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/fetch_bundle_queue_if.sv
// fetch_bundle_queue_if: enqueue/dequeue handshake, flush and occupancy bundle of the fetch bundle queue
interface fetch_bundle_queue_if
    import frontend_queue_pkg::*;
#(
    parameter int WIDTH = FETCH_BUNDLE_W,
    parameter int CNT_W = cnt_w(2)
);
    logic             io_enq_ready;
    logic             io_enq_valid;
    logic [WIDTH-1:0] io_enq_bits;
    logic             io_deq_ready;
    logic             io_deq_valid;
    logic [WIDTH-1:0] io_deq_bits;
    logic             io_flush;
    logic [CNT_W-1:0] io_count;
    logic             io_almost_full;

    modport master (
        output io_enq_valid, io_enq_bits, io_deq_ready, io_flush,
        input  io_enq_ready, io_deq_valid, io_deq_bits, io_count, io_almost_full
    );

    modport slave (
        input  io_enq_valid, io_enq_bits, io_deq_ready, io_flush,
        output io_enq_ready, io_deq_valid, io_deq_bits, io_count, io_almost_full
    );
endinterface

// File: rtl/fetch_bundle_queue_ram.sv
// fetch_queue_ram: DEPTH x WIDTH register array, one write port, one asynchronous read port, no reset
module fetch_queue_ram #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 255,
    parameter int PW = 1
) (
    input  logic             clock,
    input  logic             we_i,
    input  logic [PW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // write the enqueued payload into its slot; contents are never cleared
    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fetch_bundle_queue.sv
// fetch_bundle_queue: parametrised fetch bundle FIFO with pipe/flow modes, redirect flush and occupancy
module fetch_bundle_queue
    import frontend_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = FETCH_BUNDLE_W,
    parameter bit PIPE = 1'b1,
    parameter bit FLOW = 1'b0,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input logic clock,
    input logic reset,
    fetch_bundle_queue_if.slave q
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PW-1:0]    enq_ptr_q, enq_ptr_d, deq_ptr_q, deq_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty, full, do_enq, do_deq, bypass;
    logic [WIDTH-1:0] rd_data;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign q.io_enq_ready = ~q.io_flush & (~full | (PIPE & q.io_deq_ready));
    assign q.io_deq_valid = ~q.io_flush & (~empty | (FLOW & q.io_enq_valid));
    assign q.io_deq_bits  = (empty & FLOW) ? q.io_enq_bits : rd_data;
    assign do_enq = q.io_enq_valid & q.io_enq_ready;
    assign do_deq = q.io_deq_valid & q.io_deq_ready;
    // an empty flow-through queue hands the payload straight across without touching storage
    assign bypass = empty & FLOW & do_enq & do_deq;
    assign q.io_count       = count_q;
    assign q.io_almost_full = (count_q >= CW'(AF_LEVEL));

    // next pointers and occupancy; flush wins and empties the queue
    always_comb begin
        enq_ptr_d = enq_ptr_q;
        deq_ptr_d = deq_ptr_q;
        count_d   = count_q;
        if (q.io_flush) begin
            enq_ptr_d = '0;
            deq_ptr_d = '0;
            count_d   = '0;
        end else if (!bypass) begin
            enq_ptr_d = do_enq ? inc(enq_ptr_q) : enq_ptr_q;
            deq_ptr_d = do_deq ? inc(deq_ptr_q) : deq_ptr_q;
            count_d   = count_q + CW'(do_enq) - CW'(do_deq);
        end
    end

    // control state register, cleared immediately on reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enq_ptr_q <= '0;
            deq_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            enq_ptr_q <= enq_ptr_d;
            deq_ptr_q <= deq_ptr_d;
            count_q   <= count_d;
        end
    end

    fetch_queue_ram #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .PW(PW)
    ) u_ram (
        .clock(clock),
        .we_i(do_enq & ~bypass),
        .waddr_i(enq_ptr_q),
        .wdata_i(q.io_enq_bits),
        .raddr_i(deq_ptr_q),
        .rdata_o(rd_data)
    );
endmodule

// File: tb/tb_fetch_bundle_queue.sv
// tb_fetch_bundle_queue: directed table and sequence checks of fetch_bundle_queue in three configurations
module tb_fetch_bundle_queue;
    import frontend_queue_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    fetch_bundle_queue_if #(.WIDTH(16), .CNT_W(3)) ia ();
    fetch_bundle_queue_if #(.WIDTH(16), .CNT_W(2)) ib ();
    fetch_bundle_queue_if #(.WIDTH(FETCH_BUNDLE_W), .CNT_W(2)) ic ();

    fetch_bundle_queue #(.DEPTH(4), .WIDTH(16), .PIPE(1'b0), .FLOW(1'b0), .AF_LEVEL(3))
        dut_a (.clock(clock), .reset(reset), .q(ia));
    fetch_bundle_queue #(.DEPTH(3), .WIDTH(16), .PIPE(1'b1), .FLOW(1'b0), .AF_LEVEL(2))
        dut_b (.clock(clock), .reset(reset), .q(ib));
    fetch_bundle_queue #(.DEPTH(2), .WIDTH(FETCH_BUNDLE_W), .PIPE(1'b1), .FLOW(1'b1), .AF_LEVEL(1))
        dut_c (.clock(clock), .reset(reset), .q(ic));

    typedef struct {
        logic        ev;
        logic [15:0] eb;
        logic        dr;
        logic        fl;
        logic        er;
        logic        dv;
        logic [15:0] db;
        logic [2:0]  cnt;
        logic        af;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(logic ev, logic [15:0] eb, logic dr, logic fl,
                                logic er, logic dv, logic [15:0] db, logic [2:0] cnt, logic af);
        vec_t v;
        v.ev = ev; v.eb = eb; v.dr = dr; v.fl = fl;
        v.er = er; v.dv = dv; v.db = db; v.cnt = cnt; v.af = af;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic step_c(input string name, input logic ev, input logic [254:0] eb, input logic dr,
                          input logic er, input logic dv, input logic [254:0] db,
                          input logic [1:0] cnt, input logic af);
        ic.io_enq_valid = ev;
        ic.io_enq_bits  = eb;
        ic.io_deq_ready = dr;
        @(negedge clock);
        chk({name, " enq_ready"}, ic.io_enq_ready, er);
        chk({name, " deq_valid"}, ic.io_deq_valid, dv);
        if (dv) chk({name, " deq_bits"}, ic.io_deq_bits, db);
        chk({name, " count"}, ic.io_count, cnt);
        chk({name, " almost_full"}, ic.io_almost_full, af);
        next_cycle();
    endtask

    logic [254:0] pa, pb, pc, pd;
    int q_exp[$];
    int sent, recv;

    initial begin
        //             ev  eb      dr fl   er dv db      cnt af
        tbl[0]  = mk(0, 16'h0,   0, 0,  1, 0, 16'h0,   0, 0);
        tbl[1]  = mk(1, 16'h1,   0, 0,  1, 0, 16'h0,   0, 0);
        tbl[2]  = mk(1, 16'h2,   0, 0,  1, 1, 16'h1,   1, 0);
        tbl[3]  = mk(1, 16'h3,   0, 0,  1, 1, 16'h1,   2, 0);
        tbl[4]  = mk(1, 16'h4,   0, 0,  1, 1, 16'h1,   3, 1);
        tbl[5]  = mk(1, 16'h5,   0, 0,  0, 1, 16'h1,   4, 1);
        tbl[6]  = mk(1, 16'h5,   1, 0,  0, 1, 16'h1,   4, 1);
        tbl[7]  = mk(0, 16'h0,   1, 0,  1, 1, 16'h2,   3, 1);
        tbl[8]  = mk(0, 16'h0,   1, 0,  1, 1, 16'h3,   2, 0);
        tbl[9]  = mk(0, 16'h0,   1, 0,  1, 1, 16'h4,   1, 0);
        tbl[10] = mk(0, 16'h0,   0, 0,  1, 0, 16'h0,   0, 0);
        tbl[11] = mk(1, 16'hA1,  0, 0,  1, 0, 16'h0,   0, 0);
        tbl[12] = mk(1, 16'hA2,  0, 0,  1, 1, 16'hA1,  1, 0);
        tbl[13] = mk(1, 16'hA3,  0, 0,  1, 1, 16'hA1,  2, 0);
        tbl[14] = mk(1, 16'hA4,  1, 1,  0, 0, 16'h0,   3, 1);
        tbl[15] = mk(0, 16'h0,   0, 0,  1, 0, 16'h0,   0, 0);
        tbl[16] = mk(1, 16'hB1,  1, 0,  1, 0, 16'h0,   0, 0);
        tbl[17] = mk(0, 16'h0,   1, 0,  1, 1, 16'hB1,  1, 0);
        tbl[18] = mk(0, 16'h0,   0, 0,  1, 0, 16'h0,   0, 0);
        tbl[19] = mk(1, 16'hC1,  0, 0,  1, 0, 16'h0,   0, 0);
        tbl[20] = mk(1, 16'hC2,  1, 0,  1, 1, 16'hC1,  1, 0);
        tbl[21] = mk(0, 16'h0,   1, 0,  1, 1, 16'hC2,  1, 0);
        tbl[22] = mk(0, 16'h0,   0, 0,  1, 0, 16'h0,   0, 0);

        pa = '0;
        pa[PC_MSB:PC_LSB] = 40'h80_0000_1000;
        pa[TSRC_MSB:TSRC_LSB] = 2'b11;
        pa[MASK_MSB:MASK_LSB] = 8'hF0;
        pb = ~pa;
        pc = {pa[127:0], pa[254:128]};
        pd = 255'hAB;

        ia.io_enq_valid = 0; ia.io_enq_bits = '0; ia.io_deq_ready = 0; ia.io_flush = 0;
        ib.io_enq_valid = 0; ib.io_enq_bits = '0; ib.io_deq_ready = 0; ib.io_flush = 0;
        ic.io_enq_valid = 0; ic.io_enq_bits = '0; ic.io_deq_ready = 0; ic.io_flush = 0;

        #2;
        chk("rst A enq_ready", ia.io_enq_ready, 1'b1);
        chk("rst A deq_valid", ia.io_deq_valid, 1'b0);
        chk("rst A count", ia.io_count, 3'd0);
        chk("rst A almost_full", ia.io_almost_full, 1'b0);
        chk("rst B count", ib.io_count, 2'd0);
        chk("rst C deq_valid", ic.io_deq_valid, 1'b0);
        chk("rst C count", ic.io_count, 2'd0);
        #10 reset = 1'b0;
        next_cycle();

        for (int i = 0; i < 23; i++) begin
            ia.io_enq_valid = tbl[i].ev;
            ia.io_enq_bits  = tbl[i].eb;
            ia.io_deq_ready = tbl[i].dr;
            ia.io_flush     = tbl[i].fl;
            @(negedge clock);
            chk($sformatf("A%0d enq_ready", i), ia.io_enq_ready, tbl[i].er);
            chk($sformatf("A%0d deq_valid", i), ia.io_deq_valid, tbl[i].dv);
            if (tbl[i].dv) chk($sformatf("A%0d deq_bits", i), ia.io_deq_bits, tbl[i].db);
            chk($sformatf("A%0d count", i), ia.io_count, tbl[i].cnt);
            chk($sformatf("A%0d almost_full", i), ia.io_almost_full, tbl[i].af);
            next_cycle();
        end
        ia.io_enq_valid = 0; ia.io_deq_ready = 0; ia.io_flush = 0;

        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
            ib.io_enq_valid = (sent < 10) && ($urandom_range(0, 3) != 0);
            ib.io_enq_bits  = 16'(16'h100 + sent);
            ib.io_deq_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            chk("B count", ib.io_count, q_exp.size());
            chk("B enq_ready", ib.io_enq_ready, (q_exp.size() < 3) || ib.io_deq_ready);
            chk("B deq_valid", ib.io_deq_valid, q_exp.size() > 0);
            if (ib.io_deq_valid && ib.io_deq_ready && q_exp.size() > 0) begin
                chk($sformatf("B order %0d", recv), ib.io_deq_bits, q_exp[0]);
                void'(q_exp.pop_front());
                recv++;
            end
            if (ib.io_enq_valid && ib.io_enq_ready) begin
                q_exp.push_back(16'h100 + sent);
                sent++;
            end
            next_cycle();
        end
        chk("B all received", recv, 10);
        ib.io_enq_valid = 0; ib.io_deq_ready = 0;

        step_c("C1 flow-write", 1, pa, 0,  1, 1, pa, 2'd0, 0);
        step_c("C2 fill",       1, pb, 0,  1, 1, pa, 2'd1, 1);
        step_c("C3 pipe-full",  1, pc, 1,  1, 1, pa, 2'd2, 1);
        step_c("C4 held",       0, '0, 0,  0, 1, pb, 2'd2, 1);
        step_c("C5 drain B",    0, '0, 1,  1, 1, pb, 2'd2, 1);
        step_c("C6 drain C",    0, '0, 1,  1, 1, pc, 2'd1, 1);
        step_c("C7 bypass",     1, pd, 1,  1, 1, pd, 2'd0, 0);
        step_c("C8 empty",      0, '0, 0,  1, 0, '0, 2'd0, 0);

        ia.io_enq_valid = 1; ia.io_enq_bits = 16'h11;
        next_cycle();
        ia.io_enq_bits = 16'h22;
        next_cycle();
        ia.io_enq_valid = 0;
        #2;
        chk("R pre count", ia.io_count, 3'd2);
        chk("R pre deq_valid", ia.io_deq_valid, 1'b1);
        ic.io_enq_valid = 1;
        ic.io_enq_bits  = pd;
        reset = 1'b1;
        #1;
        chk("R A count", ia.io_count, 3'd0);
        chk("R A deq_valid", ia.io_deq_valid, 1'b0);
        chk("R A enq_ready", ia.io_enq_ready, 1'b1);
        chk("R C flow deq_valid", ic.io_deq_valid, 1'b1);
        chk("R C count", ic.io_count, 2'd0);
        ic.io_enq_valid = 0;
        #1 reset = 1'b0;
        next_cycle();
        @(negedge clock);
        chk("R post count", ia.io_count, 3'd0);
        chk("R post deq_valid", ia.io_deq_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
